// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial datapath feeders and collectors.
//   state_t   : frame sequencer states (idle, clear pulse, bit shifting)
//   frame_len : total serial frame length in bits (operand + zero pad)
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Operand bits followed by pad bits that let downstream carries flush.
  function automatic int unsigned frame_len(input int unsigned width,
                                            input int unsigned pad);
    return width + pad;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out register, LSB first, zero fill from the top.
// Ports:
//   clk, rst : clock, async active-high reset (clears the register)
//   load     : capture din (has priority over shift)
//   shift    : shift right by one, 0 enters at the MSB
//   din      : parallel load value
//   lsb      : current serial bit (register bit 0)
module piso_shift
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] sr;

  // Zero fill means bits past the operand MSB read as pad zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign lsb = sr[0];

endmodule

// File: rtl/serial_operand_tx.sv
// Parallel-to-serial operand feeder for the bit-serial arithmetic datapath.
// Accepts (a, b) on a valid/ready handshake, pulses ser_clr for one cycle,
// then streams WIDTH operand bits LSB-first followed by PAD zero bits.
// Ports:
//   clk, rst             : clock, async active-high reset
//   in_valid / in_ready  : operand handshake (in_ready decoded from state)
//   in_a, in_b           : parallel operands, sampled only on accept
//   ser_clr              : one-cycle clear of downstream carry/sum state
//   ser_valid            : ser_x/ser_y carry a frame bit
//   ser_first, ser_last  : frame bit 0 / frame bit WIDTH+PAD-1 markers
//   ser_x, ser_y         : serial bits of A and B
//   busy                 : frame in progress (clear or shift)
module serial_operand_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PAD   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_clr,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             ser_x,
  output logic             ser_y,
  output logic             busy
);

  localparam int unsigned FL   = frame_len(WIDTH, PAD);
  localparam int unsigned CW   = $clog2(FL + 1);
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  state_t        state, state_d;
  logic [CW-1:0] count, count_d;
  logic          load, shift;
  logic          x_lsb, y_lsb;
  logic          last_bit;
  logic          clr_d, valid_d, first_d, last_d, x_d, y_d, busy_d;

  // Operand shift registers
  piso_shift #(.WIDTH(WIDTH)) u_shift_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (in_a),
    .lsb   (x_lsb)
  );

  piso_shift #(.WIDTH(WIDTH)) u_shift_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (in_b),
    .lsb   (y_lsb)
  );

  // The last frame bit is the only shift cycle that can take a new pair.
  assign last_bit = (state == ST_SHIFT) && (count == LAST);
  assign in_ready = (state == ST_IDLE) || last_bit;

  // State register, bit counter and registered serial outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      ser_clr   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      ser_x     <= 1'b0;
      ser_y     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      ser_clr   <= clr_d;
      ser_valid <= valid_d;
      ser_first <= first_d;
      ser_last  <= last_d;
      ser_x     <= x_d;
      ser_y     <= y_d;
      busy      <= busy_d;
    end
  end

  // Next state plus next values of the registered outputs. Output values are
  // computed for the state being entered so they line up with that state.
  always_comb begin
    state_d = state;
    count_d = count;
    load    = 1'b0;
    shift   = 1'b0;
    clr_d   = 1'b0;
    valid_d = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    x_d     = 1'b0;
    y_d     = 1'b0;
    busy_d  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_CLEAR;
          clr_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_CLEAR: begin
        state_d = ST_SHIFT;
        shift   = 1'b1;
        count_d = '0;
        valid_d = 1'b1;
        first_d = 1'b1;
        x_d     = x_lsb;
        y_d     = y_lsb;
        busy_d  = 1'b1;
      end

      ST_SHIFT: begin
        if (count == LAST) begin
          count_d = '0;
          if (in_valid) begin
            // Back-to-back: the only bubble is the next clear cycle.
            load    = 1'b1;
            state_d = ST_CLEAR;
            clr_d   = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          shift   = 1'b1;
          count_d = count + CW'(1);
          valid_d = 1'b1;
          last_d  = (count_d == LAST);
          x_d     = x_lsb;
          y_d     = y_lsb;
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_operand_tx.sv
// Scoreboard bench for serial_operand_tx (WIDTH=4, PAD=4) with a serial
// adder model downstream that is cleared by ser_clr.
module tb_serial_operand_tx;

  localparam int W  = 4;
  localparam int P  = 4;
  localparam int FL = W + P;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         ser_clr, ser_valid, ser_first, ser_last, ser_x, ser_y, busy;

  serial_operand_tx #(.WIDTH(W), .PAD(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .ser_clr   (ser_clr),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .ser_x     (ser_x),
    .ser_y     (ser_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected output vector: {clr, valid, first, last, x, y, busy}
  typedef struct {
    int         at;
    logic [6:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   sum_q[$];

  // Issue side: every accepted pair becomes one clear cycle followed by FL
  // bit cycles, stamped with the cycle they must appear in.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      sum_q.delete();
    end else if (in_valid && in_ready) begin
      int   av, bv;
      exp_t e;
      av = int'(in_a);
      bv = int'(in_b);
      e.at = cyc + 1;
      e.v  = 7'b1000001;
      exp_q.push_back(e);
      for (int i = 0; i < FL; i++) begin
        e.at = cyc + 2 + i;
        e.v  = {1'b0, 1'b1, (i == 0), (i == FL - 1), av[i], bv[i], 1'b1};
        exp_q.push_back(e);
      end
      sum_q.push_back(av + bv);
    end
  end

  // Monitor: compares every cycle's outputs and runs the downstream adder.
  logic [6:0] got;
  logic       exp_rdy;
  int         carry, acc, idx;
  exp_t       cur;

  always @(negedge clk) begin
    if (rst) begin
      carry = 0;
      acc   = 0;
      idx   = 0;
    end else begin
      got = {ser_clr, ser_valid, ser_first, ser_last, ser_x, ser_y, busy};
      exp_rdy = (exp_q.size() == 0) || (exp_q[0].at > cyc) ||
                (exp_q[0].at == cyc && exp_q[0].v[3]);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_rdy);
      end
      checks++;
      if (exp_q.size() != 0 && exp_q[0].at == cyc) begin
        cur = exp_q.pop_front();
        if (got !== cur.v) begin
          errors++;
          $display("FAIL frame_out cyc=%0d got=%b want=%b", cyc, got, cur.v);
        end
      end else if (got !== 7'b0) begin
        errors++;
        $display("FAIL idle_out cyc=%0d got=%b want=0000000", cyc, got);
      end

      // Serial adder with carry held between bits, cleared only by ser_clr.
      if (ser_clr) begin
        carry = 0;
        acc   = 0;
        idx   = 0;
      end
      if (ser_valid) begin
        int xs, ys, s;
        xs = int'(ser_x);
        ys = int'(ser_y);
        s  = (xs + ys + carry) % 2;
        carry = (xs + ys + carry) / 2;
        acc = acc + (s << idx);
        idx++;
        if (ser_last) begin
          checks++;
          if (sum_q.size() == 0) begin
            errors++;
            $display("FAIL sum_unexpected cyc=%0d got=%0d want=none", cyc, acc);
          end else begin
            int want;
            want = sum_q.pop_front();
            if (acc != want) begin
              errors++;
              $display("FAIL adder_sum cyc=%0d got=%0d want=%0d", cyc, acc, want);
            end
          end
        end
      end
    end
  end

  // Present a pair and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout got=no_accept want=accept a=%h b=%h", a, b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({ser_clr, ser_valid, ser_first, ser_last, ser_x, ser_y, busy} !== 7'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s got=%b rdy=%b want=0000000 rdy=1", name,
               {ser_clr, ser_valid, ser_first, ser_last, ser_x, ser_y, busy}, in_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset_state");
    rst = 1'b0;
    idle(2);

    // Single frame: 11 + 6 = 17
    send(4'b1011, 4'b0110);
    idle(12);

    // Back-to-back: second pair accepted on the first frame's last bit
    send(4'hF, 4'h1);
    send(4'h3, 4'h3);
    idle(12);

    // Stall with in_valid low
    idle(5);
    @(negedge clk);
    check_quiet("stall_idle");
    @(posedge clk);
    #1;

    // Operands change while the frame shifts
    send(4'h5, 4'hA);
    for (int i = 0; i < 10; i++) begin
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(posedge clk);
      #1;
    end
    idle(3);

    // Carry flush, then a fresh frame from a cleared carry
    send(4'hF, 4'hF);
    send(4'h1, 4'h1);
    idle(12);

    // Reset in the middle of a frame
    send(4'h6, 4'h9);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_quiet("reset_midframe");
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Random traffic, inputs change every cycle regardless of state
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(posedge clk);
      #1;
    end
    idle(15);

    checks++;
    if (exp_q.size() != 0 || sum_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d pending want=0/0", exp_q.size(), sum_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
